// File: rtl/shared_counter_arbiter.sv
// Round-robin arbiter lending one WIDTH-bit up counter to NREQ requesters as a timed interval.
// Optional feature: define CNT_PERIODIC_EN to add the periodic input (auto-reload runs).
module shared_counter_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   len,
`ifdef CNT_PERIODIC_EN
    input  logic [NREQ-1:0]         periodic,
`endif
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         done,
    output logic [WIDTH-1:0]        count,
    output logic                    busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            r_state, w_state_d;
    logic [NREQ-1:0]   r_grant, w_grant_d;
    logic [NREQ-1:0]   r_done,  w_done_d;
    logic [WIDTH-1:0]  r_count, w_count_d;
    logic              r_busy,  w_busy_d;
    logic [WIDTH-1:0]  r_len,   w_len_d;
    logic [PW-1:0]     r_ptr,   w_ptr_d;
    logic              r_per,   w_per_d;

    logic              w_found;
    logic [PW-1:0]     w_winner;
    logic [PW-1:0]     w_cand;
    logic [NREQ-1:0]   w_onehot;
    logic              w_per_in;

    // Scan starts one past the last owner, so the previous owner is checked last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_cand   = r_ptr;
        for (int k = 1; k <= int'(NREQ); k++) begin
            w_cand = PW'((int'(r_ptr) + k) % int'(NREQ));
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
        w_onehot           = '0;
        w_onehot[w_winner] = 1'b1;
    end

`ifdef CNT_PERIODIC_EN
    assign w_per_in = periodic[w_winner];
`else
    assign w_per_in = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_grant_d = r_grant;
        w_done_d  = '0;
        w_count_d = r_count;
        w_len_d   = r_len;
        w_ptr_d   = r_ptr;
        w_per_d   = r_per;

        unique case (r_state)
            StIdle: begin
                w_grant_d = '0;
                w_count_d = '0;
                if (w_found) begin
                    w_state_d = StRun;
                    w_grant_d = w_onehot;
                    w_len_d   = len[int'(w_winner)*int'(WIDTH) +: WIDTH];
                    w_ptr_d   = w_winner;
                    w_per_d   = w_per_in;
                end
            end
            StRun: begin
                if (!req[r_ptr]) begin
                    // Owner withdrew: release silently, no done pulse.
                    w_state_d = StIdle;
                    w_grant_d = '0;
                    w_count_d = '0;
                end else if (r_count == r_len) begin
                    w_done_d[r_ptr] = 1'b1;
                    if (r_per) begin
                        w_count_d = '0;
                    end else begin
                        w_state_d = StDone;
                        w_grant_d = '0;
                    end
                end else begin
                    w_count_d = r_count + WIDTH'(1);
                end
            end
            StDone: begin
                w_state_d = StIdle;
                w_grant_d = '0;
                w_count_d = '0;
            end
            default: begin
                w_state_d = StIdle;
                w_grant_d = '0;
                w_count_d = '0;
            end
        endcase

        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_done  <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_len   <= '0;
            r_ptr   <= PW'(NREQ - 1);
            r_per   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_grant <= w_grant_d;
            r_done  <= w_done_d;
            r_count <= w_count_d;
            r_busy  <= w_busy_d;
            r_len   <= w_len_d;
            r_ptr   <= w_ptr_d;
            r_per   <= w_per_d;
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign count = r_count;
    assign busy  = r_busy;

endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Directed bench for shared_counter_arbiter (NREQ=2, WIDTH=3); obs = {grant, done, count, busy}.
module tb_shared_counter_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [5:0] len;
`ifdef CNT_PERIODIC_EN
    logic [1:0] periodic;
`endif
    logic [1:0] grant;
    logic [1:0] done;
    logic [2:0] count;
    logic       busy;
    logic [7:0] obs;

    int total = 0;
    int bad   = 0;

    shared_counter_arbiter #(
        .NREQ  (2),
        .WIDTH (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .len      (len),
`ifdef CNT_PERIODIC_EN
        .periodic (periodic),
`endif
        .grant    (grant),
        .done     (done),
        .count    (count),
        .busy     (busy)
    );

    assign obs = {grant, done, count, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = 2'b00;
        len   = 6'd0;
`ifdef CNT_PERIODIC_EN
        periodic = 2'b00;
`endif
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 2'b00;
        len   = 6'd0;
`ifdef CNT_PERIODIC_EN
        periodic = 2'b00;
`endif
        tick();
        tick();
        total++;
        if (obs !== 8'b00_00_000_0) begin
            bad++; $display("FAIL reset_held got=%b want=%b", obs, 8'b00_00_000_0);
        end
        reset = 1'b0;
        tick();
        total++;
        if (obs !== 8'b00_00_000_0) begin
            bad++; $display("FAIL reset_idle got=%b want=%b", obs, 8'b00_00_000_0);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req = 2'b01;
        len = {3'd0, 3'd5};
        tick();
        total++;
        if (obs !== {2'b01, 2'b00, 3'd0, 1'b1}) begin
            bad++; $display("FAIL single_grant got=%b want=%b", obs, {2'b01, 2'b00, 3'd0, 1'b1});
        end
        len = {3'd0, 3'd2};  // must be ignored after grant
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if (obs !== {2'b01, 2'b00, 3'(i), 1'b1}) begin
                bad++; $display("FAIL single_count%0d got=%b want=%b", i, obs,
                                {2'b01, 2'b00, 3'(i), 1'b1});
            end
        end
        tick();
        total++;
        if (obs !== {2'b00, 2'b01, 3'd5, 1'b1}) begin
            bad++; $display("FAIL single_done got=%b want=%b", obs, {2'b00, 2'b01, 3'd5, 1'b1});
        end
        req = 2'b00;
        tick();
        total++;
        if (obs !== 8'b00_00_000_0) begin
            bad++; $display("FAIL single_release got=%b want=%b", obs, 8'b00_00_000_0);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_seq [9];
        apply_reset();
        exp_seq[0] = {2'b01, 2'b00, 3'd0, 1'b1};
        exp_seq[1] = {2'b01, 2'b00, 3'd1, 1'b1};
        exp_seq[2] = {2'b00, 2'b01, 3'd1, 1'b1};
        exp_seq[3] = {2'b00, 2'b00, 3'd0, 1'b0};
        exp_seq[4] = {2'b10, 2'b00, 3'd0, 1'b1};
        exp_seq[5] = {2'b10, 2'b00, 3'd1, 1'b1};
        exp_seq[6] = {2'b10, 2'b00, 3'd2, 1'b1};
        exp_seq[7] = {2'b00, 2'b10, 3'd2, 1'b1};
        exp_seq[8] = {2'b00, 2'b00, 3'd0, 1'b0};
        req = 2'b11;
        len = {3'd2, 3'd1};
        for (int i = 0; i < 9; i++) begin
            if (i == 8) req = 2'b00;
            tick();
            total++;
            if (obs !== exp_seq[i]) begin
                bad++; $display("FAIL rr_step%0d got=%b want=%b", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_abort();
        apply_reset();
        req = 2'b10;
        len = {3'd6, 3'd0};
        for (int i = 0; i <= 2; i++) begin
            tick();
            total++;
            if (obs !== {2'b10, 2'b00, 3'(i), 1'b1}) begin
                bad++; $display("FAIL abort_run%0d got=%b want=%b", i, obs,
                                {2'b10, 2'b00, 3'(i), 1'b1});
            end
        end
        req = 2'b00;
        tick();
        total++;
        if (obs !== 8'b00_00_000_0) begin
            bad++; $display("FAIL abort_release got=%b want=%b", obs, 8'b00_00_000_0);
        end
        tick();
        total++;
        if (obs !== 8'b00_00_000_0) begin
            bad++; $display("FAIL abort_nodone got=%b want=%b", obs, 8'b00_00_000_0);
        end
    endtask

    task automatic test_len_bounds();
        apply_reset();
        req = 2'b01;
        len = {3'd0, 3'd0};
        tick();
        total++;
        if (obs !== {2'b01, 2'b00, 3'd0, 1'b1}) begin
            bad++; $display("FAIL len0_grant got=%b want=%b", obs, {2'b01, 2'b00, 3'd0, 1'b1});
        end
        tick();
        total++;
        if (obs !== {2'b00, 2'b01, 3'd0, 1'b1}) begin
            bad++; $display("FAIL len0_done got=%b want=%b", obs, {2'b00, 2'b01, 3'd0, 1'b1});
        end
        req = 2'b00;
        tick();
        req = 2'b01;
        len = {3'd0, 3'd7};
        for (int i = 0; i <= 7; i++) begin
            tick();
            total++;
            if (obs !== {2'b01, 2'b00, 3'(i), 1'b1}) begin
                bad++; $display("FAIL len7_count%0d got=%b want=%b", i, obs,
                                {2'b01, 2'b00, 3'(i), 1'b1});
            end
        end
        tick();
        total++;
        if (obs !== {2'b00, 2'b01, 3'd7, 1'b1}) begin
            bad++; $display("FAIL len7_done got=%b want=%b", obs, {2'b00, 2'b01, 3'd7, 1'b1});
        end
        req = 2'b00;
        tick();
        total++;
        if (obs !== 8'b00_00_000_0) begin
            bad++; $display("FAIL len7_release got=%b want=%b", obs, 8'b00_00_000_0);
        end
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        req = 2'b01;
        len = {3'd0, 3'd7};
        tick();
        tick();
        tick();
        total++;
        if (obs !== {2'b01, 2'b00, 3'd2, 1'b1}) begin
            bad++; $display("FAIL midrst_pre got=%b want=%b", obs, {2'b01, 2'b00, 3'd2, 1'b1});
        end
        reset = 1'b1;
        tick();
        total++;
        if (obs !== 8'b00_00_000_0) begin
            bad++; $display("FAIL midrst_clear got=%b want=%b", obs, 8'b00_00_000_0);
        end
        reset = 1'b0;
        req   = 2'b00;
        tick();
        total++;
        if (obs !== 8'b00_00_000_0) begin
            bad++; $display("FAIL midrst_after got=%b want=%b", obs, 8'b00_00_000_0);
        end
    endtask

`ifdef CNT_PERIODIC_EN
    task automatic test_periodic();
        apply_reset();
        req      = 2'b01;
        periodic = 2'b01;
        len      = {3'd0, 3'd3};
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (obs !== {2'b01, ((i % 4 == 0) && (i > 0)) ? 2'b01 : 2'b00, 3'(i % 4), 1'b1})
            begin
                bad++; $display("FAIL periodic_step%0d got=%b", i, obs);
            end
        end
        req = 2'b00;
        tick();
        total++;
        if (obs !== 8'b00_00_000_0) begin
            bad++; $display("FAIL periodic_abort got=%b want=%b", obs, 8'b00_00_000_0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_len_bounds();
        test_reset_mid_run();
`ifdef CNT_PERIODIC_EN
        test_periodic();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
